sha_block_sequencer: RTL and testbench

Control sequencer for the double-SHA-256 mining datapath. It steps the shared compression core and the H0–H7 chaining registers through the three compression passes of one hash attempt:
- header chunk 1, block code 1
- header chunk 2, block code 2
- second hash over the 256-bit first digest, block code 3

It also owns the 32-bit nonce counter, so the core can sweep nonces back-to-back without host involvement. It sits between the host/job interface and the round/H-register datapath.

---
 rtl/sha_seq_pkg.sv | 20 ++
 rtl/sha_round_counter.sv | 27 ++
 rtl/sha_block_sequencer.sv | 121 ++++++++++++
 tb/tb_sha_block_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sha_seq_pkg.sv
// Shared definitions for the double-SHA-256 block sequencer and its round counter.
package sha_seq_pkg;

  localparam int ROUNDS_DEF  = 64;
  localparam int NONCE_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam logic [1:0] BLK_INIT  = 2'd0;
  localparam logic [1:0] BLK_HDR1  = 2'd1;
  localparam logic [1:0] BLK_HDR2  = 2'd2;
  localparam logic [1:0] BLK_HASH2 = 2'd3;

endpackage

// File: rtl/sha_round_counter.sv
// 6-bit compression round counter with synchronous clear, enable and last-round flag.
module sha_round_counter
  import sha_seq_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] count,
  output logic       last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 6'd0;
    end else if (clr) begin
      count <= 6'd0;
    end else if (en) begin
      count <= count + 6'd1;
    end
  end

  assign last = (count == 6'(ROUNDS - 1));

endmodule

// File: rtl/sha_block_sequencer.sv
// Steps the shared SHA-256 core through header chunk 1, chunk 2 and the second hash,
// and owns the nonce counter so attempts can run back-to-back.
module sha_block_sequencer
  import sha_seq_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEF,
  parameter int NONCE_W = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_init,
  output logic [1:0]         block,
  output logic [5:0]         round,
  output logic               ws_load,
  output logic               round_en,
  output logic               h_update,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               nonce_wrap
);

  state_t             state, state_n;
  logic [1:0]         block_n;
  logic [NONCE_W-1:0] nonce_n;
  logic               wrap_n;
  logic               rnd_last;
  logic               rnd_clr;
  logic               rnd_en;

  sha_round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (rnd_clr),
    .en    (rnd_en),
    .count (round),
    .last  (rnd_last)
  );

  // round holds at its last value through UPDATE and DONE, restarts at every LOAD
  assign rnd_clr = (state_n == ST_LOAD) || (state_n == ST_IDLE);
  assign rnd_en  = (state == ST_ROUND) && !rnd_last;

  always_comb begin
    state_n = state;
    block_n = block;
    nonce_n = nonce;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LOAD;
          block_n = BLK_HDR1;
          nonce_n = nonce_init;
        end
      end
      ST_LOAD:  state_n = ST_ROUND;
      ST_ROUND: begin
        if (rnd_last) state_n = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (block == BLK_HASH2) begin
          state_n = ST_DONE;
          block_n = BLK_INIT;
        end else begin
          state_n = ST_LOAD;
          block_n = block + 2'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        if (run) begin
          nonce_n = nonce + NONCE_W'(1);
          if (!(&nonce)) begin
            state_n = ST_LOAD;
            block_n = BLK_HDR1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        block_n = BLK_INIT;
      end
    endcase
    if (abort) begin
      state_n = ST_IDLE;
      block_n = BLK_INIT;
      nonce_n = nonce;
    end
  end

  // The wrap flag is registered, so run is looked at on the edge entering DONE.
  assign wrap_n = (state_n == ST_DONE) && run && (&nonce);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      block      <= BLK_INIT;
      nonce      <= '0;
      ws_load    <= 1'b0;
      round_en   <= 1'b0;
      h_update   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nonce_wrap <= 1'b0;
    end else begin
      state      <= state_n;
      block      <= block_n;
      nonce      <= nonce_n;
      ws_load    <= (state_n == ST_LOAD);
      round_en   <= (state_n == ST_ROUND);
      h_update   <= (state_n == ST_UPDATE);
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
      nonce_wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Directed bench for sha_block_sequencer: table-driven single attempt plus corner sequences.
module tb_sha_block_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        run;
  logic        abort;
  logic [31:0] nonce_init;
  logic [1:0]  block;
  logic [5:0]  round;
  logic        ws_load;
  logic        round_en;
  logic        h_update;
  logic [31:0] nonce;
  logic        busy;
  logic        done;
  logic        nonce_wrap;

  int checks = 0;
  int errors = 0;
  int cur    = 0;
  int ws_cnt = 0;
  int hu_cnt = 0;
  int dn_cnt = 0;

  always #5 clk = ~clk;

  sha_block_sequencer #(.ROUNDS(64), .NONCE_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .abort      (abort),
    .nonce_init (nonce_init),
    .block      (block),
    .round      (round),
    .ws_load    (ws_load),
    .round_en   (round_en),
    .h_update   (h_update),
    .nonce      (nonce),
    .busy       (busy),
    .done       (done),
    .nonce_wrap (nonce_wrap)
  );

  // pulse counters: values read here are those of the cycle ending at this edge
  always @(posedge clk) begin
    if (ws_load)  ws_cnt <= ws_cnt + 1;
    if (h_update) hu_cnt <= hu_cnt + 1;
    if (done)     dn_cnt <= dn_cnt + 1;
  end

  typedef struct {
    int         cyc;
    logic [1:0] blk;
    logic [5:0] rnd;
    logic [5:0] flg;  // {ws_load, round_en, h_update, busy, done, nonce_wrap}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cur);
    end
  endtask

  task automatic goto(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic start_job(input logic [31:0] n, input logic r);
    @(negedge clk);
    nonce_init = n;
    run        = r;
    start      = 1'b1;
    cur        = 0;
    goto(1);
    start = 1'b0;
  endtask

  function automatic logic [5:0] flags();
    return {ws_load, round_en, h_update, busy, done, nonce_wrap};
  endfunction

  initial begin
    int ws0, hu0, dn0;
    vecs[0]  = '{1,   2'd1, 6'd0,  6'b100100};
    vecs[1]  = '{2,   2'd1, 6'd0,  6'b010100};
    vecs[2]  = '{17,  2'd1, 6'd15, 6'b010100};
    vecs[3]  = '{65,  2'd1, 6'd63, 6'b010100};
    vecs[4]  = '{66,  2'd1, 6'd63, 6'b001100};
    vecs[5]  = '{67,  2'd2, 6'd0,  6'b100100};
    vecs[6]  = '{68,  2'd2, 6'd0,  6'b010100};
    vecs[7]  = '{131, 2'd2, 6'd63, 6'b010100};
    vecs[8]  = '{132, 2'd2, 6'd63, 6'b001100};
    vecs[9]  = '{133, 2'd3, 6'd0,  6'b100100};
    vecs[10] = '{198, 2'd3, 6'd63, 6'b001100};
    vecs[11] = '{199, 2'd0, 6'd63, 6'b000110};
    vecs[12] = '{200, 2'd0, 6'd0,  6'b000000};

    rst = 1'b1; start = 1'b0; run = 1'b0; abort = 1'b0; nonce_init = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", {block, round, flags(), nonce}, {2'd0, 6'd0, 6'b000000, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    // single attempt, run=0
    ws0 = ws_cnt; hu0 = hu_cnt; dn0 = dn_cnt;
    start_job(32'h0000_1000, 1'b0);
    for (int i = 0; i < 13; i++) begin
      goto(vecs[i].cyc);
      chk($sformatf("vec%0d", vecs[i].cyc), {block, round, flags()},
          {vecs[i].blk, vecs[i].rnd, vecs[i].flg});
      chk($sformatf("vec%0d_nonce", vecs[i].cyc), nonce, 32'h0000_1000);
    end
    goto(201);
    chk("single_counts", {ws_cnt - ws0, hu_cnt - hu0, dn_cnt - dn0}, {32'd3, 32'd3, 32'd1});

    // continuous mode, three attempts back to back
    start_job(32'h0000_0005, 1'b1);
    goto(199);
    chk("run_done1", {done, nonce}, {1'b1, 32'h5});
    goto(200);
    chk("run_reload1", {ws_load, block, nonce, busy}, {1'b1, 2'd1, 32'h6, 1'b1});
    goto(398);
    chk("run_done2", {done, nonce}, {1'b1, 32'h6});
    goto(399);
    chk("run_reload2", {ws_load, block, nonce}, {1'b1, 2'd1, 32'h7});
    goto(597);
    chk("run_done3", {done, nonce}, {1'b1, 32'h7});
    run = 1'b0;
    goto(598);
    chk("run_stop", {busy, ws_load, nonce}, {1'b0, 1'b0, 32'h7});

    // wrap at all-ones
    start_job(32'hFFFF_FFFF, 1'b1);
    goto(198);
    ws0 = ws_cnt;
    goto(199);
    chk("wrap_done", {done, nonce_wrap, nonce}, {1'b1, 1'b1, 32'hFFFF_FFFF});
    goto(200);
    chk("wrap_after", {busy, ws_load, nonce_wrap, block, nonce}, {1'b0, 1'b0, 1'b0, 2'd0, 32'h0});
    goto(206);
    run = 1'b0;
    chk("wrap_no_reload", ws_cnt - ws0, 32'd0);

    // abort in block 2, round 2, then a clean attempt
    start_job(32'h0000_0042, 1'b0);
    goto(70);
    chk("abort_pre", {block, round, round_en}, {2'd2, 6'd2, 1'b1});
    abort = 1'b1;
    goto(71);
    abort = 1'b0;
    chk("abort_idle", {block, busy, ws_load, round_en, h_update, done, nonce},
        {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h42});
    start_job(32'h0000_0077, 1'b0);
    goto(198);
    chk("restart_nodone", done, 1'b0);
    goto(199);
    chk("restart_done", {done, nonce}, {1'b1, 32'h77});

    // start ignored while busy and when coincident with abort
    goto(202);
    ws0 = ws_cnt;
    start_job(32'h0000_0100, 1'b0);
    goto(10);
    start = 1'b1; nonce_init = 32'h0000_AAAA;
    goto(11);
    start = 1'b0;
    chk("start_busy_ignored", {nonce, block, round}, {32'h100, 2'd1, 6'd9});
    goto(20);
    abort = 1'b1;
    goto(21);
    start = 1'b1;
    goto(22);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ignored", {busy, ws_load, nonce}, {1'b0, 1'b0, 32'h100});
    goto(25);
    chk("ws_load_count", ws_cnt - ws0, 32'd1);

    // asynchronous reset mid-ROUND at round 17
    start_job(32'h0000_0300, 1'b0);
    goto(19);
    chk("rst_pre", {block, round}, {2'd1, 6'd17});
    #1 rst = 1'b1;
    #1 chk("rst_mid", {block, busy, round, done, round_en}, {2'd0, 1'b0, 6'd0, 1'b0, 1'b0});
    goto(20);
    rst = 1'b0;
    goto(23);
    chk("rst_stays_idle", {busy, ws_load, done}, {1'b0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
